// File: rtl/aux_input_conditioner.sv
// Board-input conditioner: 2-FF synchronisers, one debounce FSM per input and a
// four-phase req/ack holder that stretches a resume press for the slow core clock.
module aux_input_conditioner #(
  parameter int DebounceCnt = 1000000,
  parameter int CntBit      = 20,
  parameter int SwtWidth    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                resume_raw,
  input  logic [SwtWidth-1:0] swt_raw,
  input  logic                resume_ack,
  output logic [SwtWidth-1:0] swt_db,
  output logic                swt_chg,
  output logic                resume_db,
  output logic                resume_req,
  output logic [1:0]          dbg_req_state_o,
  output logic [SwtWidth:0]   dbg_settle_o
);

  localparam int              NumIn   = SwtWidth + 1;
  localparam logic [CntBit-1:0] CntLast = CntBit'(DebounceCnt - 1);

  typedef enum logic {
    DB_STABLE = 1'b0,
    DB_SETTLE = 1'b1
  } db_state_e;

  typedef enum logic [1:0] {
    RQ_IDLE         = 2'd0,
    RQ_REQ          = 2'd1,
    RQ_WAIT_ACK_LOW = 2'd2
  } req_state_e;

  // Resume occupies the top bit so the switch bus maps straight through.
  logic [NumIn-1:0]    raw_in;
  logic [NumIn-1:0]    sync_s0_q;
  logic [NumIn-1:0]    sync_s1_q;
  logic                ack_s0_q;
  logic                ack_s1_q;
  logic [NumIn-1:0]    db_val;
  logic [SwtWidth-1:0] db_upd;

  assign raw_in = {resume_raw, swt_raw};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_s0_q <= '0;
      sync_s1_q <= '0;
      ack_s0_q  <= 1'b0;
      ack_s1_q  <= 1'b0;
    end else begin
      sync_s0_q <= raw_in;
      sync_s1_q <= sync_s0_q;
      ack_s0_q  <= resume_ack;
      ack_s1_q  <= ack_s0_q;
    end
  end

  for (genvar gi = 0; gi < NumIn; gi++) begin : g_db
    db_state_e         state_q;
    logic [CntBit-1:0] cnt_q;
    logic              val_q;
    logic              differs;
    logic              accept;

    assign differs = sync_s1_q[gi] ^ val_q;
    assign accept  = (state_q == DB_SETTLE) && differs && (cnt_q == CntLast);

    // cnt_q counts consecutive cycles the synchronised input disagreed with val_q.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= DB_STABLE;
        cnt_q   <= '0;
        val_q   <= 1'b0;
      end else begin
        case (state_q)
          DB_STABLE: begin
            if (differs) begin
              state_q <= DB_SETTLE;
              cnt_q   <= CntBit'(1);
            end else begin
              cnt_q   <= '0;
            end
          end
          DB_SETTLE: begin
            if (!differs) begin
              state_q <= DB_STABLE;
              cnt_q   <= '0;
            end else if (cnt_q == CntLast) begin
              val_q   <= sync_s1_q[gi];
              state_q <= DB_STABLE;
              cnt_q   <= '0;
            end else begin
              cnt_q   <= cnt_q + 1'b1;
            end
          end
          default: begin
            state_q <= DB_STABLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end

    assign db_val[gi]       = val_q;
    assign dbg_settle_o[gi] = (state_q == DB_SETTLE);

    if (gi < SwtWidth) begin : g_upd
      assign db_upd[gi] = accept;
    end
  end

  assign swt_db    = db_val[SwtWidth-1:0];
  assign resume_db = db_val[SwtWidth];

  logic swt_chg_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      swt_chg_q <= 1'b0;
    end else begin
      swt_chg_q <= |db_upd;
    end
  end

  assign swt_chg = swt_chg_q;

  // Four-phase handshake: resume_req rises on a fresh press and stays high
  // until ack is seen high; a new request is only possible once ack has
  // returned low, so no press is ever half-delivered across the boundary.
  req_state_e req_state_q;
  logic       req_q;
  logic       db_prev_q;
  logic       press;

  assign press = db_val[SwtWidth] & ~db_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_state_q <= RQ_IDLE;
      req_q       <= 1'b0;
      db_prev_q   <= 1'b0;
    end else begin
      db_prev_q <= db_val[SwtWidth];
      case (req_state_q)
        RQ_IDLE: begin
          if (press) begin
            req_state_q <= RQ_REQ;
            req_q       <= 1'b1;
          end
        end
        RQ_REQ: begin
          if (ack_s1_q) begin
            req_state_q <= RQ_WAIT_ACK_LOW;
            req_q       <= 1'b0;
          end
        end
        RQ_WAIT_ACK_LOW: begin
          if (!ack_s1_q) begin
            req_state_q <= RQ_IDLE;
          end
        end
        default: begin
          req_state_q <= RQ_IDLE;
          req_q       <= 1'b0;
        end
      endcase
    end
  end

  assign resume_req      = req_q;
  assign dbg_req_state_o = req_state_q;

endmodule

// File: tb/tb_aux_input_conditioner.sv
// Randomised and directed bench for aux_input_conditioner: a window-based
// reference model pushes timed output events, a monitor pops and compares.
module tb_aux_input_conditioner;
  localparam int DebounceCnt = 4;
  localparam int CntBit      = 3;
  localparam int SwtWidth    = 16;
  localparam int W           = 64;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd2;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic                resume_raw = 1'b0;
  logic [SwtWidth-1:0] swt_raw = '0;
  logic                resume_ack = 1'b0;
  logic [SwtWidth-1:0] swt_db;
  logic                swt_chg;
  logic                resume_db;
  logic                resume_req;
  logic [1:0]          dbg_req_state_o;
  logic [SwtWidth:0]   dbg_settle_o;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [W-1:0] swt_q[$];
  logic [W-1:0] rdb_q[$];
  logic [W-1:0] req_q[$];

  always #5 clk = ~clk;

  aux_input_conditioner #(
    .DebounceCnt(DebounceCnt),
    .CntBit     (CntBit),
    .SwtWidth   (SwtWidth)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .resume_raw     (resume_raw),
    .swt_raw        (swt_raw),
    .resume_ack     (resume_ack),
    .swt_db         (swt_db),
    .swt_chg        (swt_chg),
    .resume_db      (resume_db),
    .resume_req     (resume_req),
    .dbg_req_state_o(dbg_req_state_o),
    .dbg_settle_o   (dbg_settle_o)
  );

  // ---------------- reference model ----------------
  // An input's accepted value flips when the last DebounceCnt samples seen
  // after the 2-cycle synchroniser all disagree with it.
  logic [17:0] hist[$];
  logic [16:0] m_v;
  logic [16:0] m_nv;
  logic        m_db_prev;
  logic        m_req;
  logic        m_busy;
  logic        m_old_req;
  logic        m_ack_seen;
  logic        m_rising;
  logic        m_all_diff;

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < 6; i++) hist.push_back('0);
    m_v       = '0;
    m_db_prev = 1'b0;
    m_req     = 1'b0;
    m_busy    = 1'b0;
    swt_q.delete();
    rdb_q.delete();
    req_q.delete();
  endtask

  task automatic model_step();
    cyc++;
    hist.push_back({resume_ack, resume_raw, swt_raw});
    if (hist.size() > 12) void'(hist.pop_front());
    m_ack_seen = hist[hist.size()-3][17];
    m_rising   = m_v[16] & ~m_db_prev;
    m_old_req  = m_req;
    if (!m_busy) begin
      if (m_rising) begin
        m_req  = 1'b1;
        m_busy = 1'b1;
      end
    end else if (m_req) begin
      if (m_ack_seen) m_req = 1'b0;
    end else if (!m_ack_seen) begin
      m_busy = 1'b0;
    end
    m_db_prev = m_v[16];
    m_nv = m_v;
    for (int b = 0; b < 17; b++) begin
      m_all_diff = 1'b1;
      for (int k = 0; k < DebounceCnt; k++)
        if (hist[hist.size()-3-k][b] == m_v[b]) m_all_diff = 1'b0;
      if (m_all_diff) m_nv[b] = ~m_v[b];
    end
    if (m_nv[15:0] != m_v[15:0]) swt_q.push_back({32'(cyc), 16'h0, m_nv[15:0]});
    if (m_nv[16] != m_v[16])     rdb_q.push_back({32'(cyc), 31'h0, m_nv[16]});
    if (m_req != m_old_req)      req_q.push_back({32'(cyc), 31'h0, m_req});
    m_v = m_nv;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  // ---------------- scoreboard monitor ----------------
  logic [15:0] last_swt = '0;
  logic        last_rdb = 1'b0;
  logic        last_req = 1'b0;

  task automatic evt_cmp(input string name, input logic has, input logic [W-1:0] e,
                         input logic [31:0] act, input logic ok);
    checks++;
    if (!has) begin
      errors++;
      $display("FAIL %s: unexpected output change to %h (flag %b) at cycle %0d, none expected",
               name, act, ok, cyc);
    end else if (e[63:32] !== 32'(cyc) || e[31:0] !== act || !ok) begin
      errors++;
      $display("FAIL %s: got %h (flag %b) at cycle %0d, expected %h at cycle %0d",
               name, act, ok, cyc, e[31:0], e[63:32]);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      last_swt = '0;
      last_rdb = 1'b0;
      last_req = 1'b0;
    end else begin
      if (swt_db !== last_swt || swt_chg !== 1'b0) begin
        if (swt_q.size() > 0) evt_cmp("swt_evt", 1'b1, swt_q.pop_front(), 32'(swt_db), swt_chg);
        else                  evt_cmp("swt_evt", 1'b0, '0, 32'(swt_db), swt_chg);
        last_swt = swt_db;
      end
      if (resume_db !== last_rdb) begin
        if (rdb_q.size() > 0) evt_cmp("rdb_evt", 1'b1, rdb_q.pop_front(), 32'(resume_db), 1'b1);
        else                  evt_cmp("rdb_evt", 1'b0, '0, 32'(resume_db), 1'b1);
        last_rdb = resume_db;
      end
      if (resume_req !== last_req) begin
        if (req_q.size() > 0) evt_cmp("req_evt", 1'b1, req_q.pop_front(), 32'(resume_req), 1'b1);
        else                  evt_cmp("req_evt", 1'b0, '0, 32'(resume_req), 1'b1);
        last_req = resume_req;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    model_reset();
    #1 rst_n = 1'b0;
    wait_cycles(3);
    rst_n = 1'b1;

    // Idle after reset
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_outputs", 32'({swt_db, swt_chg, resume_db, resume_req}), 32'h0);
    end

    // Switch bus latency and change pulse
    after_edge();
    swt_raw = 16'hA5C3;
    for (int k = 0; k <= 7; k++) begin
      @(negedge clk);
      if (k == 5) chk("swt_before_lat", 32'(swt_db), 32'h0);
      if (k == 6) begin
        chk("swt_lat6", 32'(swt_db), 32'hA5C3);
        chk("swt_chg_on", 32'(swt_chg), 32'h1);
      end
      if (k == 7) chk("swt_chg_off", 32'(swt_chg), 32'h0);
    end

    // Glitch rejection
    after_edge();
    swt_raw = 16'h0000;
    wait_cycles(10);
    swt_raw[0] = 1'b1;
    wait_cycles(3);
    swt_raw[0] = 1'b0;
    wait_cycles(10);
    chk("glitch_reject", 32'(swt_db), 32'h0);

    // Resume press -> request, ack high -> drop, ack low -> idle
    resume_raw = 1'b1;
    for (int k = 0; k <= 9; k++) begin
      @(negedge clk);
      if (k == 6) chk("req_before", 32'(resume_req), 32'h0);
      if (k == 7) chk("req_rise7", 32'(resume_req), 32'h1);
    end
    after_edge();
    resume_raw = 1'b0;
    wait_cycles(10);
    chk("req_held", 32'(resume_req), 32'h1);
    resume_ack = 1'b1;
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      if (k == 2) chk("req_before_fall", 32'(resume_req), 32'h1);
      if (k == 3) chk("req_fall3", 32'(resume_req), 32'h0);
    end
    chk("state_wait", 32'(dbg_req_state_o), 32'(ST_WAIT));

    // Press while ack still high is dropped
    after_edge();
    resume_raw = 1'b1;
    wait_cycles(8);
    resume_raw = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("no_req_in_wait", 32'(resume_req), 32'h0);
    end
    after_edge();
    resume_ack = 1'b0;
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      if (k == 3) chk("state_idle", 32'(dbg_req_state_o), 32'(ST_IDLE));
    end
    after_edge();
    resume_raw = 1'b1;
    for (int k = 0; k <= 7; k++) begin
      @(negedge clk);
      if (k == 7) chk("req_again", 32'(resume_req), 32'h1);
    end
    after_edge();
    resume_raw = 1'b0;
    resume_ack = 1'b1;
    wait_cycles(8);
    resume_ack = 1'b0;
    wait_cycles(8);

    // Reset during settle and during an active request
    swt_raw = 16'h00F0;
    wait_cycles(10);
    resume_raw = 1'b1;
    wait_cycles(10);
    chk("req_before_reset", 32'(resume_req), 32'h1);
    swt_raw = 16'h0F0F;
    repeat (4) @(posedge clk);
    #1;
    chk("settle_before_reset", 32'(dbg_settle_o[15:0]), 32'h0FFF);
    #1 rst_n = 1'b0;
    #1;
    chk("reset_outputs", 32'({swt_db, swt_chg, resume_db, resume_req}), 32'h0);
    chk("reset_debug", 32'({dbg_req_state_o, dbg_settle_o}), 32'h0);
    wait_cycles(2);
    rst_n = 1'b1;
    for (int k = 0; k <= 7; k++) begin
      @(negedge clk);
      if (k == 5) chk("post_rst_before", 32'({swt_db, resume_db}), 32'h0);
      if (k == 6) chk("post_rst_lat6", 32'({swt_db, resume_db}), 32'({16'h0F0F, 1'b1}));
      if (k == 7) chk("post_rst_req", 32'(resume_req), 32'h1);
    end
    after_edge();
    resume_raw = 1'b0;
    resume_ack = 1'b1;
    wait_cycles(8);
    resume_ack = 1'b0;
    wait_cycles(8);

    // Randomised phase
    for (int it = 0; it < 60; it++) begin
      int hold;
      hold = $urandom_range(1, 9);
      swt_raw    = ($urandom_range(0, 3) == 0) ? 16'($urandom) : swt_raw ^ (16'h1 << $urandom_range(0, 15));
      resume_raw = ($urandom_range(0, 2) == 0) ? ~resume_raw : resume_raw;
      resume_ack = ($urandom_range(0, 3) == 0) ? ~resume_ack : resume_ack;
      wait_cycles(hold);
    end
    resume_ack = 1'b0;
    wait_cycles(30);

    chk("swt_q_drained", 32'(swt_q.size()), 32'h0);
    chk("rdb_q_drained", 32'(rdb_q.size()), 32'h0);
    chk("req_q_drained", 32'(req_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
